// File: rtl/led_jogadores.sv
// Per-seat LED driver: idle pattern (alive/dead, blinking current player) and blocking flash announcement.
// Optional macro LEDS_ATIVO_BAIXO_EN inverts the leds output for active-low LED boards.
module led_jogadores #(
  parameter int unsigned N_JOG     = 5,
  parameter int unsigned DIV_PISCA = 25000000,
  parameter int unsigned N_PISCA   = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       jogador_atual,
  input  logic             destaca_atual,
  input  logic [N_JOG-1:0] mortes,
  input  logic             anuncia,
  input  logic [2:0]       alvo,
  output logic [N_JOG-1:0] leds,
  output logic             ocupado,
  output logic             pronto
);

  localparam int unsigned PW = (DIV_PISCA > 1) ? $clog2(DIV_PISCA) : 1;
  localparam int unsigned CW = $clog2(N_PISCA + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV_PISCA - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(N_PISCA - 1);

`ifdef LEDS_ATIVO_BAIXO_EN
  localparam logic [N_JOG-1:0] LED_POL = '1;
`else
  localparam logic [N_JOG-1:0] LED_POL = '0;
`endif

  typedef enum logic [1:0] {
    OCIOSO,
    PISCANDO,
    FIM
  } estado_t;

  estado_t          state_q, state_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             fase_q, fase_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       alvo_q, alvo_d;
  logic [N_JOG-1:0] leds_q, leds_d;
  logic             ocupado_q, ocupado_d;
  logic             pronto_q, pronto_d;

  logic             tick_c;
  logic [N_JOG-1:0] idle_c;
  logic [N_JOG-1:0] onehot_c;
  logic [N_JOG-1:0] pattern_c;

  assign tick_c = (presc_q == PRESC_MAX);

  // State register and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= OCIOSO;
      presc_q   <= '0;
      fase_q    <= 1'b0;
      cnt_q     <= '0;
      alvo_q    <= '0;
      leds_q    <= LED_POL;
      ocupado_q <= 1'b0;
      pronto_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      fase_q    <= fase_d;
      cnt_q     <= cnt_d;
      alvo_q    <= alvo_d;
      leds_q    <= leds_d;
      ocupado_q <= ocupado_d;
      pronto_q  <= pronto_d;
    end
  end

  // Next state, blink timing and LED pattern
  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    fase_d    = fase_q;
    cnt_d     = cnt_q;
    alvo_d    = alvo_q;
    idle_c    = '0;
    onehot_c  = '0;
    pattern_c = '0;

    unique case (state_q)
      OCIOSO: begin
        presc_d = tick_c ? '0 : presc_q + PW'(1);
        if (tick_c) fase_d = ~fase_q;
        if (anuncia && (32'(alvo) < N_JOG)) begin
          state_d = PISCANDO;
          alvo_d  = alvo;
          presc_d = '0;
          fase_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      PISCANDO: begin
        presc_d = tick_c ? '0 : presc_q + PW'(1);
        if (tick_c) begin
          if (fase_q) begin
            fase_d = 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            // Last off-phase done: finish instead of re-lighting
            state_d = FIM;
            presc_d = '0;
            fase_d  = 1'b0;
            cnt_d   = cnt_q + CW'(1);
          end else begin
            fase_d = 1'b1;
            cnt_d  = cnt_q + CW'(1);
          end
        end
      end
      FIM: begin
        state_d = OCIOSO;
        presc_d = '0;
        fase_d  = 1'b0;
      end
      default: begin
        state_d = OCIOSO;
        presc_d = '0;
        fase_d  = 1'b0;
      end
    endcase

    // Out-of-range indices match no seat, so they never override
    for (int unsigned i = 0; i < N_JOG; i++) begin
      idle_c[i]   = ~mortes[i];
      onehot_c[i] = (alvo_d == 3'(i));
      if (destaca_atual && (jogador_atual == 3'(i)) && !mortes[i]) begin
        idle_c[i] = fase_d;
      end
    end

    if (state_d == PISCANDO) begin
      pattern_c = fase_d ? onehot_c : '0;
    end else begin
      pattern_c = idle_c;
    end

    leds_d    = pattern_c ^ LED_POL;
    ocupado_d = (state_d == PISCANDO);
    pronto_d  = (state_d == FIM);
  end

  assign leds    = leds_q;
  assign ocupado = ocupado_q;
  assign pronto  = pronto_q;

endmodule

// File: tb/tb_led_jogadores.sv
// Directed bench for led_jogadores with DIV_PISCA=4, N_PISCA=3, N_JOG=5.
module tb_led_jogadores;

  localparam int unsigned N_JOG = 5;

`ifdef LEDS_ATIVO_BAIXO_EN
  localparam logic [N_JOG-1:0] POL = 5'b11111;
`else
  localparam logic [N_JOG-1:0] POL = 5'b00000;
`endif

  logic             clock;
  logic             reset;
  logic [2:0]       jogador_atual;
  logic             destaca_atual;
  logic [N_JOG-1:0] mortes;
  logic             anuncia;
  logic [2:0]       alvo;
  logic [N_JOG-1:0] leds;
  logic             ocupado;
  logic             pronto;

  int checks = 0;
  int errors = 0;

  led_jogadores #(
    .N_JOG    (N_JOG),
    .DIV_PISCA(4),
    .N_PISCA  (3)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .jogador_atual(jogador_atual),
    .destaca_atual(destaca_atual),
    .mortes       (mortes),
    .anuncia      (anuncia),
    .alvo         (alvo),
    .leds         (leds),
    .ocupado      (ocupado),
    .pronto       (pronto)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reset with the given idle inputs; returns at the negedge where reset is released
  task automatic apply_reset(input logic [N_JOG-1:0] m, input logic d, input logic [2:0] j);
    @(negedge clock);
    reset         = 1'b0;
    mortes        = m;
    destaca_atual = d;
    jogador_atual = j;
    anuncia       = 1'b0;
    alvo          = 3'd0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset         = 1'b0;
    mortes        = 5'b00100;
    destaca_atual = 1'b0;
    jogador_atual = 3'd0;
    anuncia       = 1'b0;
    alvo          = 3'd0;
    @(negedge clock);
    checks++;
    if (leds !== POL) begin
      errors++;
      $display("FAIL reset_leds got=%b exp=%b", leds, POL);
    end
    checks++;
    if (ocupado !== 1'b0 || pronto !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got ocupado=%b pronto=%b exp 0 0", ocupado, pronto);
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (leds !== (5'b11011 ^ POL)) begin
      errors++;
      $display("FAIL idle_mortes got=%b exp=%b", leds, 5'b11011 ^ POL);
    end
    checks++;
    if (ocupado !== 1'b0 || pronto !== 1'b0) begin
      errors++;
      $display("FAIL idle_flags got ocupado=%b pronto=%b exp 0 0", ocupado, pronto);
    end
  endtask

  task automatic test_blink();
    logic [N_JOG-1:0] exp;
    apply_reset(5'b00000, 1'b1, 3'd1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      exp = (((k / 4) % 2) == 1) ? 5'b11111 : 5'b11101;
      checks++;
      if (leds !== (exp ^ POL)) begin
        errors++;
        $display("FAIL blink k=%0d got=%b exp=%b", k, leds, exp ^ POL);
      end
    end
    mortes = 5'b00010;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      checks++;
      if (leds !== (5'b11101 ^ POL)) begin
        errors++;
        $display("FAIL blink_dead k=%0d got=%b exp=%b", k, leds, 5'b11101 ^ POL);
      end
    end
    mortes = 5'b00000;
    jogador_atual = 3'd6;
    for (int k = 0; k < 16; k++) begin
      @(negedge clock);
      if (k == 8) jogador_atual = 3'd5;
      checks++;
      if (leds !== (5'b11111 ^ POL)) begin
        errors++;
        $display("FAIL blink_range k=%0d got=%b exp=%b", k, leds, 5'b11111 ^ POL);
      end
    end
  endtask

  // Announcement of seat 3; optionally a second request mid-flight that must be ignored
  task automatic test_announce(input bit inject);
    logic [N_JOG-1:0] exp;
    int n_pronto;
    n_pronto = 0;
    apply_reset(5'b00001, 1'b0, 3'd0);
    repeat (3) @(negedge clock);
    anuncia = 1'b1;
    alvo    = 3'd3;
    for (int j = 0; j < 24; j++) begin
      @(negedge clock);
      if (j == 0) begin
        anuncia = 1'b0;
        alvo    = 3'd2;
      end
      if (inject && j == 5) begin
        anuncia = 1'b1;
        alvo    = 3'd0;
      end
      if (inject && j == 6) anuncia = 1'b0;
      if (pronto === 1'b1) n_pronto++;
      exp = (((j / 4) % 2) == 0) ? 5'b01000 : 5'b00000;
      checks++;
      if (leds !== (exp ^ POL) || ocupado !== 1'b1 || pronto !== 1'b0) begin
        errors++;
        $display("FAIL announce inj=%0d j=%0d got leds=%b ocupado=%b pronto=%b exp leds=%b ocupado=1 pronto=0",
                 inject, j, leds, ocupado, pronto, exp ^ POL);
      end
    end
    @(negedge clock);
    if (pronto === 1'b1) n_pronto++;
    checks++;
    if (leds !== (5'b11110 ^ POL) || ocupado !== 1'b0 || pronto !== 1'b1) begin
      errors++;
      $display("FAIL announce_end inj=%0d got leds=%b ocupado=%b pronto=%b exp leds=%b ocupado=0 pronto=1",
               inject, leds, ocupado, pronto, 5'b11110 ^ POL);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (pronto === 1'b1) n_pronto++;
      checks++;
      if (leds !== (5'b11110 ^ POL) || ocupado !== 1'b0 || pronto !== 1'b0) begin
        errors++;
        $display("FAIL announce_after inj=%0d k=%0d got leds=%b ocupado=%b pronto=%b exp leds=%b 0 0",
                 inject, k, leds, ocupado, pronto, 5'b11110 ^ POL);
      end
    end
    checks++;
    if (n_pronto != 1) begin
      errors++;
      $display("FAIL pronto_count inj=%0d got=%0d exp=1", inject, n_pronto);
    end
  endtask

  task automatic test_invalid_alvo();
    apply_reset(5'b00001, 1'b0, 3'd0);
    @(negedge clock);
    anuncia = 1'b1;
    alvo    = 3'd7;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (k == 0) alvo = 3'd5;
      if (k == 1) anuncia = 1'b0;
      checks++;
      if (leds !== (5'b11110 ^ POL) || ocupado !== 1'b0 || pronto !== 1'b0) begin
        errors++;
        $display("FAIL invalid_alvo k=%0d got leds=%b ocupado=%b pronto=%b exp leds=%b 0 0",
                 k, leds, ocupado, pronto, 5'b11110 ^ POL);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset(5'b00000, 1'b0, 3'd0);
    @(negedge clock);
    anuncia = 1'b1;
    alvo    = 3'd4;
    for (int j = 0; j <= 10; j++) begin
      @(negedge clock);
      if (j == 0) anuncia = 1'b0;
    end
    checks++;
    if (leds !== (5'b10000 ^ POL) || ocupado !== 1'b1) begin
      errors++;
      $display("FAIL mid_announce got leds=%b ocupado=%b exp leds=%b ocupado=1", leds, ocupado, 5'b10000 ^ POL);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (leds !== POL || ocupado !== 1'b0 || pronto !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got leds=%b ocupado=%b pronto=%b exp leds=%b 0 0", leds, ocupado, pronto, POL);
    end
    @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      checks++;
      if (pronto !== 1'b0 || ocupado !== 1'b0) begin
        errors++;
        $display("FAIL post_reset k=%0d got ocupado=%b pronto=%b exp 0 0", k, ocupado, pronto);
      end
    end
  endtask

  initial begin
    reset         = 1'b0;
    jogador_atual = 3'd0;
    destaca_atual = 1'b0;
    mortes        = '0;
    anuncia       = 1'b0;
    alvo          = 3'd0;
    test_reset();
    test_blink();
    test_announce(1'b0);
    test_announce(1'b1);
    test_invalid_alvo();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
